cv_smooth: RTL and testbench

Time-multiplexed four-channel control-voltage conditioner between the SPI ADC front end and the expo/PWM consumers in the oscillator core. It accepts the four 12-bit ADC results with their per-channel valid strobes and applies a per-channel one-pole IIR low-pass filter plus output hysteresis. It presents each smoothed value with its own valid pulse. A single shared arithmetic path is scheduled round-robin by a small state machine, so the block drops in where raw `a0..a3` / `a0_v..a3_v` currently feed `expo_calc` and the LED PWMs.

---
 rtl/cv_smooth.sv | 172 +++++++++++++++++
 tb/tb_cv_smooth.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_smooth.sv
// Four-channel CV smoother: shared one-pole IIR + hysteresis, round-robin over channels.
// Strobe-to-valid latency 4 cycles, one sample per 3 cycles; no backpressure, a re-strobe overwrites the pending sample.
module cv_smooth #(
    parameter int SHIFT = 3,
    parameter int HYST  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] in0,
    input  logic [11:0] in1,
    input  logic [11:0] in2,
    input  logic [11:0] in3,
    input  logic        in0_v,
    input  logic        in1_v,
    input  logic        in2_v,
    input  logic        in3_v,
    output logic [11:0] out0,
    output logic [11:0] out1,
    output logic [11:0] out2,
    output logic [11:0] out3,
    output logic        out0_v,
    output logic        out1_v,
    output logic        out2_v,
    output logic        out3_v,
    output logic        busy
);

    localparam int          ACCW   = 12 + SHIFT;
    localparam logic [12:0] HYST13 = 13'(HYST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [11:0]       w_in [4];
    logic [3:0]        w_in_v;

    logic [11:0]       r_hold [4];
    logic [3:0]        r_pend;
    logic [3:0]        r_primed;
    logic [ACCW-1:0]   r_acc [4];
    logic [ACCW-1:0]   r_acc_n;
    logic [11:0]       r_work;
    logic [11:0]       r_out [4];
    logic [3:0]        r_out_v;
    logic [1:0]        r_last;
    logic              r_busy;

    logic              w_any;
    logic [1:0]        w_grant;
    logic [3:0]        w_clr;
    logic              w_do_grant;
    logic              w_do_calc;
    logic              w_do_write;
    logic [ACCW-1:0]   w_acc_cur;
    logic [ACCW-1:0]   w_acc_calc;
    logic [11:0]       w_y;
    logic signed [12:0] w_diff;
    logic [12:0]       w_abs;
    logic              w_upd;

    assign w_in[0] = in0;
    assign w_in[1] = in1;
    assign w_in[2] = in2;
    assign w_in[3] = in3;
    assign w_in_v  = {in3_v, in2_v, in1_v, in0_v};

    // Walk offsets from farthest to nearest so the nearest pending channel after r_last wins.
    always_comb begin
        w_any   = |r_pend;
        w_grant = r_last + 2'd1;
        for (int i = 4; i >= 1; i--) begin
            if (r_pend[r_last + 2'(i)]) begin
                w_grant = r_last + 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_any ? S_CALC : S_IDLE;
            S_CALC:  w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_do_grant = (r_state == S_IDLE) && w_any;
        w_do_calc  = (r_state == S_CALC);
        w_do_write = (r_state == S_WRITE);
    end

    // r_last doubles as the channel in service from grant through write.
    always_comb begin
        w_clr      = w_do_grant ? (4'b0001 << w_grant) : 4'b0000;
        w_acc_cur  = r_acc[r_last];
        w_acc_calc = r_primed[r_last] ? (w_acc_cur - (w_acc_cur >> SHIFT) + ACCW'(r_work))
                                      : (ACCW'(r_work) << SHIFT);
        w_y        = r_acc_n[ACCW-1:SHIFT];
        w_diff     = $signed({1'b0, w_y}) - $signed({1'b0, r_out[r_last]});
        w_abs      = w_diff[12] ? 13'(-w_diff) : 13'(w_diff);
        w_upd      = !r_primed[r_last] || (w_abs > HYST13);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_hold[i] <= '0;
                r_acc[i]  <= '0;
                r_out[i]  <= '0;
            end
            r_pend   <= '0;
            r_primed <= '0;
            r_acc_n  <= '0;
            r_work   <= '0;
            r_out_v  <= '0;
            r_last   <= 2'd3;
            r_busy   <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_in_v[i]) begin
                    r_hold[i] <= w_in[i];
                end
            end
            // A strobe landing on the grant cycle keeps the channel pending.
            r_pend  <= (r_pend & ~w_clr) | w_in_v;
            r_out_v <= '0;
            r_busy  <= (w_next != S_IDLE);
            if (w_do_grant) begin
                r_work <= r_hold[w_grant];
                r_last <= w_grant;
            end
            if (w_do_calc) begin
                r_acc_n <= w_acc_calc;
            end
            if (w_do_write) begin
                r_acc[r_last] <= r_acc_n;
                if (w_upd) begin
                    r_out[r_last] <= w_y;
                end
                r_primed[r_last] <= 1'b1;
                r_out_v[r_last]  <= 1'b1;
            end
        end
    end

    assign out0   = r_out[0];
    assign out1   = r_out[1];
    assign out2   = r_out[2];
    assign out3   = r_out[3];
    assign out0_v = r_out_v[0];
    assign out1_v = r_out_v[1];
    assign out2_v = r_out_v[2];
    assign out3_v = r_out_v[3];
    assign busy   = r_busy;

endmodule

// File: tb/tb_cv_smooth.sv
// Randomised and directed bench for cv_smooth against a per-channel filter model and a round-robin schedule.
module tb_cv_smooth;

    localparam int S = 3;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic        in0_v = 1'b0, in1_v = 1'b0, in2_v = 1'b0, in3_v = 1'b0;
    logic [11:0] out0, out1, out2, out3;
    logic        out0_v, out1_v, out2_v, out3_v;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    int m_acc [4];
    bit m_primed [4];
    int m_out [4];
    int m_last;

    cv_smooth #(.SHIFT(S), .HYST(H)) dut (
        .clk(clk), .reset(reset),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .in0_v(in0_v), .in1_v(in1_v), .in2_v(in2_v), .in3_v(in3_v),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out0_v(out0_v), .out1_v(out1_v), .out2_v(out2_v), .out3_v(out3_v),
        .busy(busy)
    );

    always #10 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_acc[i] = 0;
            m_primed[i] = 0;
            m_out[i] = 0;
        end
        m_last = 3;
    endfunction

    function automatic int model_step(int ch, int x);
        int y;
        if (!m_primed[ch]) m_acc[ch] = x * (1 << S);
        else               m_acc[ch] = m_acc[ch] - m_acc[ch] / (1 << S) + x;
        y = m_acc[ch] / (1 << S);
        if (!m_primed[ch] || (y - m_out[ch]) > H || (m_out[ch] - y) > H) m_out[ch] = y;
        m_primed[ch] = 1;
        m_last = ch;
        return m_out[ch];
    endfunction

    function automatic int get_out(int ch);
        case (ch)
            0: return int'(out0);
            1: return int'(out1);
            2: return int'(out2);
            default: return int'(out3);
        endcase
    endfunction

    function automatic logic get_v(int ch);
        case (ch)
            0: return out0_v;
            1: return out1_v;
            2: return out2_v;
            default: return out3_v;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        in0_v = 1'b0; in1_v = 1'b0; in2_v = 1'b0; in3_v = 1'b0;
    endtask

    task automatic send(input logic [3:0] mask, input int v0, input int v1, input int v2, input int v3);
        if (mask[0]) in0 = 12'(v0);
        if (mask[1]) in1 = 12'(v1);
        if (mask[2]) in2 = 12'(v2);
        if (mask[3]) in3 = 12'(v3);
        in0_v = mask[0]; in1_v = mask[1]; in2_v = mask[2]; in3_v = mask[3];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 10; k++) begin
            for (int ch = 0; ch < 4; ch++) begin
                n_checks++;
                if (get_v(ch) !== 1'b0 || get_out(ch) !== 0) begin
                    n_fail++;
                    $display("FAIL reset_ch%0d: out=%0d v=%b, required out=0 v=0", ch, get_out(ch), get_v(ch));
                end
            end
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy: busy=%b required 0", busy);
            end
            tick();
        end
    endtask

    task automatic test_prime_latency();
        int exp_o;
        exp_o = model_step(2, 1234);
        send(4'b0100, 0, 0, 1234, 0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++;
            if (out2_v !== (k == 4)) begin
                n_fail++;
                $display("FAIL prime_v2 cycle t+%0d: v=%b required %b", k, out2_v, (k == 4));
            end
            n_checks++;
            if (busy !== (k == 2 || k == 3)) begin
                n_fail++;
                $display("FAIL prime_busy cycle t+%0d: busy=%b required %b", k, busy, (k == 2 || k == 3));
            end
            if (k == 4) begin
                n_checks++;
                if (out2 !== 12'd1234 || int'(out2) !== exp_o) begin
                    n_fail++;
                    $display("FAIL prime_out2: out2=%0d required 1234", out2);
                end
            end
        end
    endtask

    task automatic test_step();
        int exp_o;
        int prev;
        exp_o = model_step(0, 0);
        send(4'b0001, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) tick();
        n_checks++;
        if (out0_v !== 1'b1 || int'(out0) !== exp_o) begin
            n_fail++;
            $display("FAIL step_prime: out0=%0d v=%b required out0=%0d v=1", out0, out0_v, exp_o);
        end
        prev = 0;
        for (int i = 0; i < 80; i++) begin
            exp_o = model_step(0, 4095);
            send(4'b0001, 4095, 0, 0, 0);
            for (int k = 1; k <= 4; k++) tick();
            n_checks++;
            if (out0_v !== 1'b1 || int'(out0) !== exp_o) begin
                n_fail++;
                $display("FAIL step_%0d: out0=%0d v=%b required out0=%0d v=1", i, out0, out0_v, exp_o);
            end
            if (i < 2) begin
                n_checks++;
                if (int'(out0) !== ((i == 0) ? 511 : 959)) begin
                    n_fail++;
                    $display("FAIL step_early_%0d: out0=%0d required %0d", i, out0, (i == 0) ? 511 : 959);
                end
            end
            n_checks++;
            if (int'(out0) < prev) begin
                n_fail++;
                $display("FAIL step_monotonic_%0d: out0=%0d below previous %0d", i, out0, prev);
            end
            prev = int'(out0);
        end
        n_checks++;
        if (4095 - int'(out0) > H) begin
            n_fail++;
            $display("FAIL step_settle: out0=%0d required within %0d of 4095", out0, H);
        end
    endtask

    task automatic test_hysteresis();
        int vals [3] = '{2000, 2016, 2016};
        int fixed [3] = '{2000, 2000, 2003};
        int exp_o;
        for (int i = 0; i < 3; i++) begin
            exp_o = model_step(1, vals[i]);
            send(4'b0010, 0, vals[i], 0, 0);
            for (int k = 1; k <= 4; k++) tick();
            n_checks++;
            if (out1_v !== 1'b1 || int'(out1) !== exp_o || int'(out1) !== fixed[i]) begin
                n_fail++;
                $display("FAIL hyst_%0d: out1=%0d v=%b required out1=%0d v=1", i, out1, out1_v, fixed[i]);
            end
        end
    endtask

    task automatic test_random();
        int exp_cyc [4];
        int exp_val [4];
        int vals [4];
        int n, last, ch, d;
        logic [3:0] mask;
        for (int it = 0; it < 12; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int c = 0; c < 4; c++) begin
                vals[c] = int'($urandom_range(0, 4095));
                if ($urandom_range(0, 1) == 1) begin
                    d = int'($urandom_range(0, 8)) - 4;
                    vals[c] = m_out[c] + d;
                    if (vals[c] < 0) vals[c] = 0;
                    if (vals[c] > 4095) vals[c] = 4095;
                end
                exp_cyc[c] = -1;
                exp_val[c] = 0;
            end
            n = 0;
            last = m_last;
            for (int off = 1; off <= 4; off++) begin
                ch = (last + off) % 4;
                if (mask[ch]) begin
                    exp_cyc[ch] = 4 + 3 * n;
                    exp_val[ch] = model_step(ch, vals[ch]);
                    n++;
                end
            end
            send(mask, vals[0], vals[1], vals[2], vals[3]);
            for (int k = 1; k <= 4 + 3 * n + 2; k++) begin
                tick();
                for (int c = 0; c < 4; c++) begin
                    n_checks++;
                    if (get_v(c) !== (exp_cyc[c] == k)) begin
                        n_fail++;
                        $display("FAIL rand_%0d_v%0d cycle t+%0d: v=%b required %b", it, c, k, get_v(c), (exp_cyc[c] == k));
                    end
                    if (exp_cyc[c] == k) begin
                        n_checks++;
                        if (get_out(c) !== exp_val[c]) begin
                            n_fail++;
                            $display("FAIL rand_%0d_out%0d: out=%0d required %0d", it, c, get_out(c), exp_val[c]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_simul_collision();
        int ev_cyc [9] = '{4, 7, 10, 13, 4+20, 7+20, 10+20, 13+20, 16+20};
        int ev_ch  [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 1};
        int ev_val [9];
        int a [4];
        int b [4];
        int c1, ch1_pulses;
        logic exp_v;
        int exp_o;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            a[i] = int'($urandom_range(0, 4095));
            b[i] = int'($urandom_range(0, 4095));
        end
        c1 = (b[1] + 2048) % 4096;
        for (int e = 0; e < 4; e++) ev_val[e] = model_step(ev_ch[e], a[ev_ch[e]]);
        for (int e = 4; e < 8; e++) ev_val[e] = model_step(ev_ch[e], b[ev_ch[e]]);
        ev_val[8] = model_step(1, c1);
        ch1_pulses = 0;
        send(4'b1111, a[0], a[1], a[2], a[3]);
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 20) send(4'b1111, b[0], b[1], b[2], b[3]);
            if (k == 24) send(4'b0010, 0, c1, 0, 0);
            for (int c = 0; c < 4; c++) begin
                exp_v = 1'b0;
                exp_o = 0;
                for (int e = 0; e < 9; e++) begin
                    if (ev_cyc[e] == k && ev_ch[e] == c) begin
                        exp_v = 1'b1;
                        exp_o = ev_val[e];
                    end
                end
                n_checks++;
                if (get_v(c) !== exp_v) begin
                    n_fail++;
                    $display("FAIL simul_v%0d cycle %0d: v=%b required %b", c, k, get_v(c), exp_v);
                end
                if (exp_v) begin
                    n_checks++;
                    if (get_out(c) !== exp_o) begin
                        n_fail++;
                        $display("FAIL simul_out%0d cycle %0d: out=%0d required %0d", c, k, get_out(c), exp_o);
                    end
                end
            end
            if (k > 20 && out1_v === 1'b1) ch1_pulses++;
        end
        n_checks++;
        if (ch1_pulses != 2) begin
            n_fail++;
            $display("FAIL collision_ch1_count: pulses=%0d required 2", ch1_pulses);
        end
    endtask

    task automatic test_reset_mid();
        int v3;
        send(4'b1111, 100, 200, 300, 400);
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 5) reset = 1'b1;
            if (k == 6) reset = 1'b0;
            if (k >= 5) begin
                for (int c = 0; c < 4; c++) begin
                    n_checks++;
                    if (get_v(c) !== 1'b0 || (k >= 6 && get_out(c) !== 0)) begin
                        n_fail++;
                        $display("FAIL rstmid_ch%0d cycle %0d: out=%0d v=%b required v=0 (out=0 after reset)", c, k, get_out(c), get_v(c));
                    end
                end
                if (k >= 6) begin
                    n_checks++;
                    if (busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rstmid_busy cycle %0d: busy=%b required 0", k, busy);
                    end
                end
            end
        end
        model_reset();
        v3 = int'($urandom_range(1, 4095));
        void'(model_step(3, v3));
        send(4'b1000, 0, 0, 0, v3);
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if (out3_v !== (k == 4)) begin
                n_fail++;
                $display("FAIL rstmid_prime_v3 cycle t+%0d: v=%b required %b", k, out3_v, (k == 4));
            end
            if (k == 4) begin
                n_checks++;
                if (int'(out3) !== v3) begin
                    n_fail++;
                    $display("FAIL rstmid_prime_out3: out3=%0d required %0d", out3, v3);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_prime_latency();
        test_step();
        test_hysteresis();
        test_random();
        test_simul_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
